// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a classic 5-stage in-order core.
// The controller detects load-use hazards, taken branches, I-side and D-side
// cache misses, and HLT retirement. It then steers the PC, IF/ID and ID/EX
// pipeline controls.
//
// Optional feature (macro HAZARD_PERFCNT_EN):
//   When defined, stallCycles counts every cycle in which the PC is held and
//   the core is not halted. The count saturates at all-ones.
//   When undefined, stallCycles is tied to zero and no counter flops exist.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   idexMemRead, idexDstReg  EX-stage load flag and destination register
//   ifidRs/Rt, ifidUsesRs/Rt ID-stage source registers and their use flags
//   ifidIsStore              ID instruction is a store (Rt = store data)
//   branchTaken              branch resolved taken in ID
//   icacheMiss/icacheDone    I-side miss / fill complete
//   dcacheMiss/dcacheDone    D-side miss / fill complete
//   haltWb                   HLT retiring in WB
//   pcWrite, ifidWrite       PC and IF/ID register write enables
//   ifidFlush, idexBubble    squash IF/ID, inject bubble into ID/EX
//   pipeFreeze, halted       whole-pipe freeze, core halted
//   stallCycles              saturating stall-cycle count
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idexMemRead,
  input  logic [3:0]       idexDstReg,
  input  logic [3:0]       ifidRs,
  input  logic [3:0]       ifidRt,
  input  logic             ifidUsesRs,
  input  logic             ifidUsesRt,
  input  logic             ifidIsStore,
  input  logic             branchTaken,
  input  logic             icacheMiss,
  input  logic             icacheDone,
  input  logic             dcacheMiss,
  input  logic             dcacheDone,
  input  logic             haltWb,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             idexBubble,
  output logic             pipeFreeze,
  output logic             halted,
  output logic [CNT_W-1:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ISTALL = 2'd1,
    DSTALL = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic rs_hit;
  logic rt_hit;
  logic ld_use;

  // Load-use detection. Store data read through Rt is exempt because it is
  // forwarded MEM-to-MEM. Register 0 is hard-wired zero and never a hazard.
  always_comb begin
    rs_hit = ifidUsesRs && (idexDstReg == ifidRs);
    rt_hit = ifidUsesRt && (idexDstReg == ifidRt) && !ifidIsStore;
    ld_use = idexMemRead && (idexDstReg != 4'd0) && (rs_hit || rt_hit);
  end

  // Next-state logic. D-miss outranks I-miss, which outranks HLT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dcacheMiss) begin
          state_d = DSTALL;
        end else if (icacheMiss) begin
          state_d = ISTALL;
        end else if (haltWb) begin
          state_d = HALT;
        end else begin
          state_d = RUN;
        end
      end
      ISTALL: begin
        if (dcacheMiss) begin
          state_d = DSTALL;
        end else if (icacheDone) begin
          state_d = RUN;
        end else begin
          state_d = ISTALL;
        end
      end
      DSTALL: begin
        // haltWb is deliberately not sampled here; it is seen again in RUN.
        if (dcacheDone) begin
          state_d = RUN;
        end else begin
          state_d = DSTALL;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pipeline controls. These come from the state and the live inputs, so a
  // miss raised in RUN freezes the pipe in the same cycle.
  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    pipeFreeze = 1'b0;
    halted     = 1'b0;
    case (state_q)
      RUN, ISTALL: begin
        if (dcacheMiss) begin
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          pipeFreeze = 1'b1;
        end else if (icacheMiss || (state_q == ISTALL)) begin
          // Feed NOPs into ID while the fill is outstanding.
          pcWrite   = 1'b0;
          ifidWrite = 1'b1;
          ifidFlush = 1'b1;
        end else if (ld_use) begin
          // Hold PC and IF/ID one cycle; the bubble also masks any branch flush.
          pcWrite    = 1'b0;
          ifidWrite  = 1'b0;
          idexBubble = 1'b1;
        end else if (branchTaken) begin
          ifidFlush = 1'b1;
        end else begin
          pcWrite   = 1'b1;
          ifidWrite = 1'b1;
        end
      end
      DSTALL: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        pipeFreeze = 1'b1;
      end
      HALT: begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        pipeFreeze = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        pcWrite   = 1'b1;
        ifidWrite = 1'b1;
      end
    endcase
  end

`ifdef HAZARD_PERFCNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Stall counter increment with saturation.
  always_comb begin
    if (!pcWrite && (state_q != HALT) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
`else
  assign stallCycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
`ifdef HAZARD_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, halted}
  localparam logic [5:0] O_RUN = 6'b110000;
  localparam logic [5:0] O_LDU = 6'b000100;
  localparam logic [5:0] O_BR  = 6'b111000;
  localparam logic [5:0] O_FRZ = 6'b000010;
  localparam logic [5:0] O_IST = 6'b011000;
  localparam logic [5:0] O_HLT = 6'b000011;

  logic             clk;
  logic             rst;
  logic             idexMemRead;
  logic [3:0]       idexDstReg;
  logic [3:0]       ifidRs;
  logic [3:0]       ifidRt;
  logic             ifidUsesRs;
  logic             ifidUsesRt;
  logic             ifidIsStore;
  logic             branchTaken;
  logic             icacheMiss;
  logic             icacheDone;
  logic             dcacheMiss;
  logic             dcacheDone;
  logic             haltWb;
  logic             pcWrite;
  logic             ifidWrite;
  logic             ifidFlush;
  logic             idexBubble;
  logic             pipeFreeze;
  logic             halted;
  logic [CNT_W-1:0] stallCycles;

  int vectors;
  int miscompares;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .idexMemRead (idexMemRead),
    .idexDstReg  (idexDstReg),
    .ifidRs      (ifidRs),
    .ifidRt      (ifidRt),
    .ifidUsesRs  (ifidUsesRs),
    .ifidUsesRt  (ifidUsesRt),
    .ifidIsStore (ifidIsStore),
    .branchTaken (branchTaken),
    .icacheMiss  (icacheMiss),
    .icacheDone  (icacheDone),
    .dcacheMiss  (dcacheMiss),
    .dcacheDone  (dcacheDone),
    .haltWb      (haltWb),
    .pcWrite     (pcWrite),
    .ifidWrite   (ifidWrite),
    .ifidFlush   (ifidFlush),
    .idexBubble  (idexBubble),
    .pipeFreeze  (pipeFreeze),
    .halted      (halted),
    .stallCycles (stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze, halted};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int n);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = 32'(stallCycles);
    exp = PERF ? 32'(n) : 32'd0;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idexMemRead = 1'b0; idexDstReg = 4'd0; ifidRs = 4'd0; ifidRt = 4'd0;
    ifidUsesRs = 1'b0; ifidUsesRt = 1'b0; ifidIsStore = 1'b0;
    branchTaken = 1'b0; icacheMiss = 1'b0; icacheDone = 1'b0;
    dcacheMiss = 1'b0; dcacheDone = 1'b0; haltWb = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    #1;
    chk("reset_out", O_RUN);
    chk_cnt("reset_cnt", 0);

    nxt(); rst = 1'b0; #1;
    chk("idle_run", O_RUN);

    // D-miss: miss cycle plus four DSTALL cycles frozen, done on the fourth.
    nxt(); dcacheMiss = 1'b1; #1; chk("dmiss_c0", O_FRZ);
    nxt(); dcacheMiss = 1'b0; #1; chk("dmiss_c1", O_FRZ);
    nxt(); haltWb = 1'b1;     #1; chk("dmiss_c2_haltwb", O_FRZ);
    nxt(); haltWb = 1'b0;     #1; chk("dmiss_c3", O_FRZ);
    nxt(); dcacheDone = 1'b1; #1; chk("dmiss_c4_done", O_FRZ);
    nxt(); dcacheDone = 1'b0; #1; chk("dmiss_back_run", O_RUN);
    chk_cnt("dmiss_cnt", 5);

    // Load-use on Rs.
    nxt(); idexMemRead = 1'b1; idexDstReg = 4'd3; ifidRs = 4'd3; ifidUsesRs = 1'b1; #1;
    chk("ldu_rs", O_LDU);
    nxt(); idle(); #1; chk("ldu_rs_after", O_RUN);
    // Load-use on Rt, non-store.
    nxt(); idexMemRead = 1'b1; idexDstReg = 4'd7; ifidRt = 4'd7; ifidUsesRt = 1'b1; #1;
    chk("ldu_rt", O_LDU);
    // Same Rt match but store: exempt.
    nxt(); idle(); idexMemRead = 1'b1; idexDstReg = 4'd5; ifidRt = 4'd5;
    ifidUsesRt = 1'b1; ifidIsStore = 1'b1; #1;
    chk("store_exempt", O_RUN);
    // r0 destination is never a hazard.
    nxt(); idle(); idexMemRead = 1'b1; ifidUsesRs = 1'b1; #1;
    chk("ldu_r0", O_RUN);
    // Register match without a load.
    nxt(); idle(); idexDstReg = 4'd9; ifidRs = 4'd9; ifidUsesRs = 1'b1; #1;
    chk("no_load", O_RUN);
    // Match on a register the instruction does not read.
    nxt(); idle(); idexMemRead = 1'b1; idexDstReg = 4'd4; ifidRs = 4'd4; #1;
    chk("unused_rs", O_RUN);

    // Branch alone, then branch with load-use, then branch alone.
    nxt(); idle(); branchTaken = 1'b1; #1; chk("branch", O_BR);
    nxt(); idexMemRead = 1'b1; idexDstReg = 4'd3; ifidRs = 4'd3; ifidUsesRs = 1'b1; #1;
    chk("branch_ldu", O_LDU);
    nxt(); idle(); branchTaken = 1'b1; #1; chk("branch_after_ldu", O_BR);
    nxt(); idle(); #1; chk("run_after_branch", O_RUN);
    chk_cnt("ldu_cnt", 8);

    // Priority: both misses in RUN -> DSTALL, then RUN -> ISTALL.
    nxt(); icacheMiss = 1'b1; dcacheMiss = 1'b1; #1; chk("both_miss", O_FRZ);
    nxt(); dcacheMiss = 1'b0; #1; chk("prio_dstall", O_FRZ);
    nxt(); dcacheDone = 1'b1; #1; chk("prio_ddone", O_FRZ);
    nxt(); dcacheDone = 1'b0; #1; chk("prio_run_imiss", O_IST);
    nxt(); #1; chk("prio_istall", O_IST);
    nxt(); idexMemRead = 1'b1; idexDstReg = 4'd3; ifidRs = 4'd3; ifidUsesRs = 1'b1; #1;
    chk("istall_ldu_ignored", O_IST);
    nxt(); idle(); dcacheMiss = 1'b1; #1; chk("istall_dmiss", O_FRZ);
    nxt(); dcacheMiss = 1'b0; #1; chk("istall_to_dstall", O_FRZ);
    nxt(); dcacheDone = 1'b1; #1; chk("dstall2_done", O_FRZ);
    nxt(); dcacheDone = 1'b0; #1; chk("prio_back_run", O_RUN);
    chk_cnt("prio_cnt", 17);

    // Plain I-miss.
    nxt(); icacheMiss = 1'b1; #1; chk("imiss_c0", O_IST);
    nxt(); icacheMiss = 1'b0; #1; chk("imiss_c1", O_IST);
    nxt(); icacheDone = 1'b1; #1; chk("imiss_done", O_IST);
    nxt(); icacheDone = 1'b0; #1; chk("imiss_back_run", O_RUN);
    chk_cnt("imiss_cnt", 20);

    // Halt: held for many cycles, inputs ignored, counter frozen.
    nxt(); haltWb = 1'b1; #1; chk("halt_req", O_RUN);
    nxt(); haltWb = 1'b0; #1; chk("halt_enter", O_HLT);
    for (int i = 0; i < 11; i++) begin
      nxt();
      dcacheMiss = (i == 3);
      icacheDone = (i == 5);
      #1;
      chk("halt_hold", O_HLT);
    end
    idle();
    chk_cnt("halt_cnt", 20);

    // Asynchronous reset leaves HALT immediately.
    nxt(); rst = 1'b1; #1;
    chk("halt_rst_out", O_RUN);
    chk_cnt("halt_rst_cnt", 0);
    nxt(); rst = 1'b0; #1; chk("post_rst_run", O_RUN);

    // Reset mid-stall abandons the D-miss.
    nxt(); dcacheMiss = 1'b1; #1; chk("mid_dmiss", O_FRZ);
    nxt(); dcacheMiss = 1'b0; #1; chk("mid_dstall", O_FRZ);
    nxt(); rst = 1'b1; #1;
    chk("mid_rst_out", O_RUN);
    chk_cnt("mid_rst_cnt", 0);
    nxt(); rst = 1'b0; #1; chk("mid_rst_run", O_RUN);
    nxt(); #1; chk("mid_rst_stays_run", O_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
